// File: rtl/tetris_pkg.sv
// Shared types and helpers for the falling-piece sequencer and its partners.
package tetris_pkg;

  localparam int BOARD_W_C = 10;
  localparam int BOARD_H_C = 20;

  typedef enum logic [1:0] {
    CMD_LEFT,
    CMD_RIGHT,
    CMD_ROTATE,
    CMD_SOFT_DROP
  } command_t;

  typedef enum logic [2:0] {
    PIECE_I,
    PIECE_O,
    PIECE_T,
    PIECE_S,
    PIECE_Z,
    PIECE_J,
    PIECE_L
  } piece_type_t;

  typedef enum logic [1:0] {
    ROT_0,
    ROT_90,
    ROT_180,
    ROT_270
  } rotation_t;

  // Position is the top-left corner of the piece's 4x4 grid.
  typedef struct packed {
    piece_type_t ptype;
    rotation_t   rot;
    logic [3:0]  x;
    logic [4:0]  y;
  } active_piece_t;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    SPAWN_CHK,
    READY,
    MOVE_CHK,
    LOCK,
    OVER
  } ctrl_state_t;

  typedef enum logic [1:0] {
    MOVE_DOWN,
    MOVE_SIDE,
    MOVE_ROT
  } move_kind_t;

  function automatic rotation_t next_rotation(rotation_t r);
    rotation_t n;
    case (r)
      ROT_0:   n = ROT_90;
      ROT_90:  n = ROT_180;
      ROT_180: n = ROT_270;
      default: n = ROT_0;
    endcase
    return n;
  endfunction

  function automatic active_piece_t make_piece(piece_type_t t, rotation_t r,
                                               logic [3:0] x, logic [4:0] y);
    active_piece_t p;
    p.ptype = t;
    p.rot   = r;
    p.x     = x;
    p.y     = y;
    return p;
  endfunction

endpackage

// File: rtl/tetris_piece_ctrl_if.sv
// Handshake bundle between the piece sequencer and its environment
// (command source, randomizer, collision checker, board writer).
interface tetris_piece_ctrl_if;
  import tetris_pkg::*;

  logic          start;
  logic          gravity_tick;
  logic          cmd_valid;
  command_t      cmd;
  logic          cmd_ready;
  piece_type_t   next_piece;
  logic          next_piece_ack;
  logic          chk_req;
  active_piece_t chk_piece;
  logic          chk_ack;
  logic          chk_hit;
  logic          lock_req;
  active_piece_t lock_piece;
  logic          lock_ack;
  logic [2:0]    lock_lines;
  active_piece_t piece;
  logic          piece_valid;
  logic [15:0]   lines_total;
  logic          game_over;

  modport master (
    input  start, gravity_tick, cmd_valid, cmd, next_piece,
           chk_ack, chk_hit, lock_ack, lock_lines,
    output cmd_ready, next_piece_ack, chk_req, chk_piece,
           lock_req, lock_piece, piece, piece_valid, lines_total, game_over
  );

  modport slave (
    output start, gravity_tick, cmd_valid, cmd, next_piece,
           chk_ack, chk_hit, lock_ack, lock_lines,
    input  cmd_ready, next_piece_ack, chk_req, chk_piece,
           lock_req, lock_piece, piece, piece_valid, lines_total, game_over
  );

endinterface

// File: rtl/tetris_move_gen.sv
// Combinational candidate builder: applies one gravity step or one player
// command to the committed piece and flags the board-edge clamps.
module tetris_move_gen
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_C,
  parameter int BOARD_H = BOARD_H_C
) (
  input  active_piece_t piece_i,
  input  command_t      cmd_i,
  input  logic          gravity_i,
  output active_piece_t cand_o,
  output move_kind_t    kind_o,
  output logic          clamp_reject_o,
  output logic          force_lock_o
);

  logic          floor_hit;
  active_piece_t down_piece;

  assign floor_hit  = (piece_i.y == 5'(BOARD_H - 1));
  assign down_piece = make_piece(piece_i.ptype, piece_i.rot, piece_i.x, piece_i.y + 5'd1);

  // Gravity overrides the command; a step off the floor becomes a lock.
  always_comb begin
    cand_o         = piece_i;
    kind_o         = MOVE_DOWN;
    clamp_reject_o = 1'b0;
    force_lock_o   = 1'b0;
    if (gravity_i) begin
      cand_o       = down_piece;
      force_lock_o = floor_hit;
    end else begin
      case (cmd_i)
        CMD_LEFT: begin
          cand_o         = make_piece(piece_i.ptype, piece_i.rot, piece_i.x - 4'd1, piece_i.y);
          kind_o         = MOVE_SIDE;
          clamp_reject_o = (piece_i.x == 4'd0);
        end
        CMD_RIGHT: begin
          cand_o         = make_piece(piece_i.ptype, piece_i.rot, piece_i.x + 4'd1, piece_i.y);
          kind_o         = MOVE_SIDE;
          clamp_reject_o = (piece_i.x == 4'(BOARD_W - 1));
        end
        CMD_ROTATE: begin
          cand_o = make_piece(piece_i.ptype, next_rotation(piece_i.rot), piece_i.x, piece_i.y);
          kind_o = MOVE_ROT;
        end
        default: begin
          cand_o       = down_piece;
          force_lock_o = floor_hit;
        end
      endcase
    end
  end

endmodule

// File: rtl/tetris_piece_ctrl.sv
// Active-piece sequencer: spawns, moves and locks the falling piece by
// negotiating with the collision checker and the board writer.
module tetris_piece_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_C,
  parameter int BOARD_H = BOARD_H_C,
  parameter int SPAWN_X = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tetris_piece_ctrl_if.master  bus
);

  ctrl_state_t   state_q, state_d;
  active_piece_t piece_q, piece_d;
  active_piece_t cand_q, cand_d;
  move_kind_t    kind_q, kind_d;
  logic          piece_valid_q, piece_valid_d;
  logic [15:0]   lines_q, lines_d;
  logic          grav_q, grav_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          npa_q, npa_d;
  logic          chk_req_q, chk_req_d;
  logic          lock_req_q, lock_req_d;
  logic          game_over_q, game_over_d;

  logic          grav_consume;
  logic          handshake;
  active_piece_t gen_cand;
  move_kind_t    gen_kind;
  logic          gen_reject;
  logic          gen_force;

  function automatic logic [15:0] sat_add(logic [15:0] a, logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign handshake = bus.cmd_valid && cmd_ready_q;

  tetris_move_gen #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H)
  ) u_move_gen (
    .piece_i        (piece_q),
    .cmd_i          (bus.cmd),
    .gravity_i      (grav_q),
    .cand_o         (gen_cand),
    .kind_o         (gen_kind),
    .clamp_reject_o (gen_reject),
    .force_lock_o   (gen_force)
  );

  // Next-state, datapath updates and registered output values.
  always_comb begin
    state_d       = state_q;
    piece_d       = piece_q;
    cand_d        = cand_q;
    kind_d        = kind_q;
    piece_valid_d = piece_valid_q;
    lines_d       = lines_q;
    grav_consume  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          lines_d = '0;
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        cand_d       = make_piece(bus.next_piece, ROT_0, 4'(SPAWN_X), 5'd0);
        kind_d       = MOVE_DOWN;
        grav_consume = 1'b1;
        state_d      = SPAWN_CHK;
      end
      SPAWN_CHK: begin
        if (bus.chk_ack) begin
          if (bus.chk_hit) begin
            piece_valid_d = 1'b0;
            state_d       = OVER;
          end else begin
            piece_d       = cand_q;
            piece_valid_d = 1'b1;
            state_d       = READY;
          end
        end
      end
      READY: begin
        // Pending gravity is serviced before any command is looked at.
        if (grav_q || handshake) begin
          grav_consume = grav_q;
          if (gen_reject) begin
            state_d = READY;
          end else if (gen_force) begin
            state_d = LOCK;
          end else begin
            cand_d  = gen_cand;
            kind_d  = gen_kind;
            state_d = MOVE_CHK;
          end
        end
      end
      MOVE_CHK: begin
        if (bus.chk_ack) begin
          if (!bus.chk_hit) begin
            piece_d = cand_q;
            state_d = READY;
          end else if (kind_q == MOVE_DOWN) begin
            state_d = LOCK;
          end else begin
            state_d = READY;
          end
        end
      end
      LOCK: begin
        if (bus.lock_ack) begin
          lines_d       = sat_add(lines_q, bus.lock_lines);
          piece_valid_d = 1'b0;
          state_d       = SPAWN;
        end
      end
      OVER: begin
        piece_valid_d = 1'b0;
        if (bus.start) begin
          lines_d = '0;
          state_d = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase

    grav_d = (grav_q && !grav_consume) ||
             (bus.gravity_tick && (state_q != IDLE) && (state_q != OVER));

    npa_d       = (state_d == SPAWN);
    chk_req_d   = (state_d == SPAWN_CHK) || (state_d == MOVE_CHK);
    lock_req_d  = (state_d == LOCK);
    cmd_ready_d = (state_d == READY) && !grav_d;
    game_over_d = (state_d == OVER);
  end

  // State and output registers; reset clears control and data alike.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      piece_q       <= '0;
      cand_q        <= '0;
      kind_q        <= MOVE_DOWN;
      piece_valid_q <= 1'b0;
      lines_q       <= '0;
      grav_q        <= 1'b0;
      cmd_ready_q   <= 1'b0;
      npa_q         <= 1'b0;
      chk_req_q     <= 1'b0;
      lock_req_q    <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      piece_q       <= piece_d;
      cand_q        <= cand_d;
      kind_q        <= kind_d;
      piece_valid_q <= piece_valid_d;
      lines_q       <= lines_d;
      grav_q        <= grav_d;
      cmd_ready_q   <= cmd_ready_d;
      npa_q         <= npa_d;
      chk_req_q     <= chk_req_d;
      lock_req_q    <= lock_req_d;
      game_over_q   <= game_over_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.next_piece_ack = npa_q;
  assign bus.chk_req        = chk_req_q;
  assign bus.chk_piece      = cand_q;
  assign bus.lock_req       = lock_req_q;
  assign bus.lock_piece     = piece_q;
  assign bus.piece          = piece_q;
  assign bus.piece_valid    = piece_valid_q;
  assign bus.lines_total    = lines_q;
  assign bus.game_over      = game_over_q;

endmodule

// File: tb/tb_tetris_piece_ctrl.sv
// Directed bench for the falling-piece sequencer.
module tb_tetris_piece_ctrl;
  import tetris_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  tetris_piece_ctrl_if bus();

  tetris_piece_ctrl #(
    .BOARD_W (10),
    .BOARD_H (20),
    .SPAWN_X (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] pc(input logic [2:0] t, input logic [1:0] r,
                                     input logic [3:0] x, input logic [4:0] y);
    return {t, r, x, y};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_piece"},    32'(bus.piece), 32'h0);
    check({tag, "_pvalid"},   32'(bus.piece_valid), 32'h0);
    check({tag, "_chkreq"},   32'(bus.chk_req), 32'h0);
    check({tag, "_chkpiece"}, 32'(bus.chk_piece), 32'h0);
    check({tag, "_lockreq"},  32'(bus.lock_req), 32'h0);
    check({tag, "_lockpc"},   32'(bus.lock_piece), 32'h0);
    check({tag, "_npa"},      32'(bus.next_piece_ack), 32'h0);
    check({tag, "_cmdrdy"},   32'(bus.cmd_ready), 32'h0);
    check({tag, "_lines"},    32'(bus.lines_total), 32'h0);
    check({tag, "_gover"},    32'(bus.game_over), 32'h0);
  endtask

  // Issue one command from READY and answer its check.
  task automatic cmd_move(input string tag, input command_t c, input logic hit,
                          input logic [13:0] exp_cand, input logic [13:0] exp_piece);
    check({tag, "_rdy"}, 32'(bus.cmd_ready), 32'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    tick();
    bus.cmd_valid = 1'b0;
    check({tag, "_req"},    32'(bus.chk_req), 32'h1);
    check({tag, "_busy"},   32'(bus.cmd_ready), 32'h0);
    check({tag, "_cand"},   32'(bus.chk_piece), 32'(exp_cand));
    bus.chk_ack = 1'b1;
    bus.chk_hit = hit;
    tick();
    bus.chk_ack = 1'b0;
    bus.chk_hit = 1'b0;
    check({tag, "_piece"},  32'(bus.piece), 32'(exp_piece));
    check({tag, "_rdy2"},   32'(bus.cmd_ready), 32'h1);
  endtask

  // One gravity step from READY, accepted by the checker.
  task automatic grav_step();
    bus.gravity_tick = 1'b1;
    tick();
    bus.gravity_tick = 1'b0;
    tick();
    bus.chk_ack = 1'b1;
    tick();
    bus.chk_ack = 1'b0;
  endtask

  // From SPAWN: spawn, soft drop into a hit, lock with n lines; ends in SPAWN.
  task automatic lock_cycle(input logic [2:0] n);
    tick();
    bus.chk_ack = 1'b1;
    bus.chk_hit = 1'b0;
    tick();
    bus.chk_ack   = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = CMD_SOFT_DROP;
    tick();
    bus.cmd_valid = 1'b0;
    bus.chk_ack   = 1'b1;
    bus.chk_hit   = 1'b1;
    tick();
    bus.chk_ack    = 1'b0;
    bus.chk_hit    = 1'b0;
    bus.lock_ack   = 1'b1;
    bus.lock_lines = n;
    tick();
    bus.lock_ack   = 1'b0;
    bus.lock_lines = 3'd0;
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.gravity_tick = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd          = CMD_LEFT;
    bus.next_piece   = PIECE_T;
    bus.chk_ack      = 1'b0;
    bus.chk_hit      = 1'b0;
    bus.lock_ack     = 1'b0;
    bus.lock_lines   = 3'd0;
    tick();
    tick();
    reset_n = 1'b1;
    check_reset("rst");

    // Spawn T
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("spawn_npa", 32'(bus.next_piece_ack), 32'h1);
    check("spawn_noreq", 32'(bus.chk_req), 32'h0);
    tick();
    check("spawn_npa_off", 32'(bus.next_piece_ack), 32'h0);
    check("spawn_req", 32'(bus.chk_req), 32'h1);
    check("spawn_cand", 32'(bus.chk_piece), 32'(pc(3'd2, 2'd0, 4'd3, 5'd0)));
    bus.chk_ack = 1'b1;
    tick();
    bus.chk_ack = 1'b0;
    check("spawn_piece", 32'(bus.piece), 32'(pc(3'd2, 2'd0, 4'd3, 5'd0)));
    check("spawn_valid", 32'(bus.piece_valid), 32'h1);
    check("spawn_rdy", 32'(bus.cmd_ready), 32'h1);

    // Moves with no hit
    cmd_move("right", CMD_RIGHT, 1'b0, pc(3'd2, 2'd0, 4'd4, 5'd0), pc(3'd2, 2'd0, 4'd4, 5'd0));
    cmd_move("rot1", CMD_ROTATE, 1'b0, pc(3'd2, 2'd1, 4'd4, 5'd0), pc(3'd2, 2'd1, 4'd4, 5'd0));
    cmd_move("rot2", CMD_ROTATE, 1'b0, pc(3'd2, 2'd2, 4'd4, 5'd0), pc(3'd2, 2'd2, 4'd4, 5'd0));
    cmd_move("rot3", CMD_ROTATE, 1'b0, pc(3'd2, 2'd3, 4'd4, 5'd0), pc(3'd2, 2'd3, 4'd4, 5'd0));
    cmd_move("rot4", CMD_ROTATE, 1'b0, pc(3'd2, 2'd0, 4'd4, 5'd0), pc(3'd2, 2'd0, 4'd4, 5'd0));
    cmd_move("left1", CMD_LEFT, 1'b0, pc(3'd2, 2'd0, 4'd3, 5'd0), pc(3'd2, 2'd0, 4'd3, 5'd0));
    cmd_move("left2", CMD_LEFT, 1'b0, pc(3'd2, 2'd0, 4'd2, 5'd0), pc(3'd2, 2'd0, 4'd2, 5'd0));
    cmd_move("left3", CMD_LEFT, 1'b0, pc(3'd2, 2'd0, 4'd1, 5'd0), pc(3'd2, 2'd0, 4'd1, 5'd0));
    cmd_move("left4", CMD_LEFT, 1'b0, pc(3'd2, 2'd0, 4'd0, 5'd0), pc(3'd2, 2'd0, 4'd0, 5'd0));

    // Left clamp at x=0
    bus.cmd_valid = 1'b1;
    bus.cmd       = CMD_LEFT;
    tick();
    bus.cmd_valid = 1'b0;
    check("clamp_noreq", 32'(bus.chk_req), 32'h0);
    check("clamp_rdy", 32'(bus.cmd_ready), 32'h1);
    check("clamp_piece", 32'(bus.piece), 32'(pc(3'd2, 2'd0, 4'd0, 5'd0)));

    // Gravity tick together with an accepted command
    bus.gravity_tick = 1'b1;
    bus.cmd_valid    = 1'b1;
    bus.cmd          = CMD_RIGHT;
    tick();
    bus.gravity_tick = 1'b0;
    bus.cmd_valid    = 1'b0;
    check("prio_cand", 32'(bus.chk_piece), 32'(pc(3'd2, 2'd0, 4'd1, 5'd0)));
    bus.chk_ack = 1'b1;
    tick();
    bus.chk_ack = 1'b0;
    check("prio_piece", 32'(bus.piece), 32'(pc(3'd2, 2'd0, 4'd1, 5'd0)));
    check("prio_rdy_low", 32'(bus.cmd_ready), 32'h0);
    tick();
    check("prio_grav_req", 32'(bus.chk_req), 32'h1);
    check("prio_grav_cand", 32'(bus.chk_piece), 32'(pc(3'd2, 2'd0, 4'd1, 5'd1)));
    // Three ticks during the check collapse into one step
    bus.gravity_tick = 1'b1;
    tick();
    tick();
    tick();
    bus.gravity_tick = 1'b0;
    check("multi_held", 32'(bus.chk_req), 32'h1);
    bus.chk_ack = 1'b1;
    tick();
    bus.chk_ack = 1'b0;
    check("multi_piece1", 32'(bus.piece), 32'(pc(3'd2, 2'd0, 4'd1, 5'd1)));
    check("multi_rdy_low", 32'(bus.cmd_ready), 32'h0);
    tick();
    check("multi_cand", 32'(bus.chk_piece), 32'(pc(3'd2, 2'd0, 4'd1, 5'd2)));
    bus.chk_ack = 1'b1;
    tick();
    bus.chk_ack = 1'b0;
    check("multi_piece2", 32'(bus.piece), 32'(pc(3'd2, 2'd0, 4'd1, 5'd2)));
    check("multi_rdy", 32'(bus.cmd_ready), 32'h1);
    tick();
    check("multi_no_extra", 32'(bus.chk_req), 32'h0);

    // Side hit leaves piece unchanged
    cmd_move("sidehit", CMD_RIGHT, 1'b1, pc(3'd2, 2'd0, 4'd2, 5'd2), pc(3'd2, 2'd0, 4'd1, 5'd2));

    // Soft-drop hit locks
    bus.next_piece = PIECE_I;
    bus.cmd_valid  = 1'b1;
    bus.cmd        = CMD_SOFT_DROP;
    tick();
    bus.cmd_valid = 1'b0;
    check("sd_cand", 32'(bus.chk_piece), 32'(pc(3'd2, 2'd0, 4'd1, 5'd3)));
    bus.chk_ack = 1'b1;
    bus.chk_hit = 1'b1;
    tick();
    bus.chk_ack = 1'b0;
    bus.chk_hit = 1'b0;
    check("sd_lockreq", 32'(bus.lock_req), 32'h1);
    check("sd_lockpc", 32'(bus.lock_piece), 32'(pc(3'd2, 2'd0, 4'd1, 5'd2)));
    bus.lock_ack = 1'b1;
    tick();
    bus.lock_ack = 1'b0;
    check("sd_npa", 32'(bus.next_piece_ack), 32'h1);
    check("sd_lines", 32'(bus.lines_total), 32'h0);
    check("sd_pvalid", 32'(bus.piece_valid), 32'h0);

    // Spawn I and fall to the floor
    tick();
    check("i_cand", 32'(bus.chk_piece), 32'(pc(3'd0, 2'd0, 4'd3, 5'd0)));
    bus.chk_ack = 1'b1;
    tick();
    bus.chk_ack = 1'b0;
    for (int i = 0; i < 19; i++) grav_step();
    check("floor_piece", 32'(bus.piece), 32'(pc(3'd0, 2'd0, 4'd3, 5'd19)));
    bus.gravity_tick = 1'b1;
    tick();
    bus.gravity_tick = 1'b0;
    tick();
    check("floor_lockreq", 32'(bus.lock_req), 32'h1);
    check("floor_nochk", 32'(bus.chk_req), 32'h0);
    check("floor_lockpc", 32'(bus.lock_piece), 32'(pc(3'd0, 2'd0, 4'd3, 5'd19)));
    bus.lock_ack   = 1'b1;
    bus.lock_lines = 3'd2;
    tick();
    bus.lock_ack   = 1'b0;
    bus.lock_lines = 3'd0;
    check("floor_lines", 32'(bus.lines_total), 32'h2);
    check("floor_npa", 32'(bus.next_piece_ack), 32'h1);
    check("floor_lockoff", 32'(bus.lock_req), 32'h0);

    // Spawn hit → game over; start ignored in SPAWN_CHK
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ign_start_req", 32'(bus.chk_req), 32'h1);
    check("ign_start_npa", 32'(bus.next_piece_ack), 32'h0);
    bus.chk_ack = 1'b1;
    bus.chk_hit = 1'b1;
    tick();
    bus.chk_ack = 1'b0;
    bus.chk_hit = 1'b0;
    check("over_flag", 32'(bus.game_over), 32'h1);
    check("over_pvalid", 32'(bus.piece_valid), 32'h0);
    check("over_lines_kept", 32'(bus.lines_total), 32'h2);
    tick();
    check("over_held", 32'(bus.game_over), 32'h1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_gover", 32'(bus.game_over), 32'h0);
    check("restart_lines", 32'(bus.lines_total), 32'h0);
    check("restart_npa", 32'(bus.next_piece_ack), 32'h1);

    // Saturation: 16383*4 + 1 = 16'hFFFD, then +4 saturates
    for (int i = 0; i < 16383; i++) lock_cycle(3'd4);
    lock_cycle(3'd1);
    check("sat_fffd", 32'(bus.lines_total), 32'hFFFD);
    lock_cycle(3'd4);
    check("sat_ffff", 32'(bus.lines_total), 32'hFFFF);

    // Reset during MOVE_CHK
    tick();
    bus.chk_ack = 1'b1;
    tick();
    bus.chk_ack   = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = CMD_RIGHT;
    tick();
    bus.cmd_valid = 1'b0;
    check("mr_req", 32'(bus.chk_req), 32'h1);
    reset_n = 1'b0;
    tick();
    check_reset("mr");
    reset_n = 1'b1;
    tick();
    check("mr_idle_rdy", 32'(bus.cmd_ready), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tetris_piece_ctrl.md
# tetris_piece_ctrl

Sequencer for the active falling piece in the GAME_clk domain. It takes player commands (command_t) and gravity ticks, forms a candidate active_piece_t, and asks the collision checker whether the candidate is legal. It then commits or discards the move, locks landed pieces into the board via the board writer, spawns the next piece from the randomizer, and flags game over.

## Interface
- BOARD_W, 10, board columns
- BOARD_H, 20, board rows
- SPAWN_X, 3, spawn column (top-left of 4x4 grid)
- clk  in  1  game clock
- reset_n  in  1  reset; synchronous, active-low
- start  in  1  pulse; starts or restarts a game
- gravity_tick  in  1  pulse; one gravity step requested
- cmd_valid  in  1  command present
- cmd  in  2  command_t
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- next_piece  in  3  piece_type_t from randomizer
- next_piece_ack  out  1  pulse; next_piece consumed
- chk_req  out  1  collision check request, held until chk_ack
- chk_piece  out  14  candidate active_piece_t, stable while chk_req
- chk_ack  in  1  pulse; result valid
- chk_hit  in  1  candidate overlaps a cell or a wall (valid with chk_ack)
- lock_req  out  1  merge piece into board, held until lock_ack
- lock_piece  out  14  piece to merge (equals piece)
- lock_ack  in  1  pulse; merge and line clear done
- lock_lines  in  3  lines cleared (0..4), valid with lock_ack
- piece  out  14  committed active piece
- piece_valid  out  1  piece is on the board
- lines_total  out  16  lines cleared this game, saturates at 16'hFFFF
- game_over  out  1  held high until start

## Operation
- States: IDLE, SPAWN, SPAWN_CHK, READY, MOVE_CHK, LOCK, OVER.
- IDLE: on start → SPAWN; clear lines_total.
- SPAWN: load candidate = {next_piece, ROT_0, x=SPAWN_X, y=0}; pulse next_piece_ack for 1 cycle; clear gravity pending; → SPAWN_CHK.
- SPAWN_CHK: chk_req=1. On chk_ack with hit → OVER. Without hit → commit piece, piece_valid=1, → READY.
- READY: gravity pending has priority. Pending → candidate y+1, kind DOWN. Else on cmd handshake:
  - LEFT: x-1.
  - RIGHT: x+1.
  - ROTATE: rotation+1 mod 4, ROT_270 wraps to ROT_0.
  - SOFT_DROP: y+1, kind DOWN.
  - Then → MOVE_CHK.
- Hard clamps, no check issued: LEFT at x==0 and RIGHT at x==BOARD_W-1 are dropped and the FSM stays in READY. DOWN at y==BOARD_H-1 is treated as a hit and goes directly to LOCK. Finer wall checks (empty grid columns) belong to the checker.
- MOVE_CHK: chk_req=1. On chk_ack:
  - No hit → commit candidate, → READY.
  - Hit on DOWN → LOCK.
  - Hit on any other kind → discard candidate, → READY.
- LOCK: lock_req=1, lock_piece=piece. On lock_ack:
  - lines_total += lock_lines, saturating.
  - piece_valid=0.
  - → SPAWN.
- OVER: game_over=1, piece_valid=0. On start → clear game_over and lines_total, → SPAWN.
- cmd_ready = (state==READY) && !gravity_pending. Commands are never queued.
- Gravity pending is a sticky flag. It is set by gravity_tick in any state except IDLE and OVER, where ticks are ignored. Multiple ticks collapse into one step. A tick in the same cycle the flag is consumed re-arms it. A tick in the same cycle a command is accepted is not lost; it is serviced at the next READY.
- start in states other than IDLE and OVER is ignored.
- chk_ack or lock_ack arriving outside its wait state is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE.
  - piece = 0, piece_valid = 0.
  - chk_req = 0, chk_piece = 0.
  - lock_req = 0, lock_piece = 0.
  - next_piece_ack = 0, cmd_ready = 0.
  - lines_total = 0, game_over = 0.
  - gravity pending = 0.
- Command handshake at cycle N → chk_req high at N+1. chk_ack at cycle M → piece updated and cmd_ready high at M+1. chk_ack may arrive in the same cycle chk_req first rises.
- start at N → next_piece_ack at N+1 → chk_req at N+2.
- lock_ack at N → next_piece_ack at N+1.
- reset_n low in any state, including mid-check or mid-lock: next edge returns to reset values. Partner blocks must drop a pending ack.

## Structure
- Add to tetris_pkg:
  - ctrl_state_t enum for the FSM states.
  - move_kind_t enum: MOVE_DOWN, MOVE_SIDE, MOVE_ROT.
  - BOARD_W_C / BOARD_H_C constants.
  - function next_rotation(rotation_t).
  - Candidate construction reuses make_piece.
- Sub-module tetris_move_gen, combinational: (piece, cmd or gravity) → candidate, move_kind, clamp_reject, force_lock. The FSM, pending flag and score counter stay in tetris_piece_ctrl.

## Test plan
- Spawn: start with next_piece=PIECE_T, chk_hit=0 → next_piece_ack 1 cycle, chk_piece={T,ROT_0,3,0}, then piece_valid=1.
- Moves: RIGHT, ROTATE×4, LEFT, all with no hit → x 3→4→3. Rotation sequence 0,90,180,270,0. cmd_ready low during each check.
- Clamp and lock at floor: LEFT at x=0 → no chk_req, piece unchanged. Gravity at y=19 → lock_req with no check. lock_ack with lines 2 → lines_total=2, next spawn.
- Gravity priority: gravity_tick and cmd_valid in the same READY cycle → cmd accepted, gravity serviced next READY. 3 ticks during a check → exactly one y+1.
- Hit on a side move → piece unchanged. Hit on soft drop → LOCK. lines_total saturates at 16'hFFFF after lock_lines=4 at 16'hFFFD.
- Spawn hit → game_over=1, start ignored until OVER, then restarts. reset_n low during MOVE_CHK → all outputs at reset values next cycle.
